// File: rtl/ddr_port_arbiter.sv
// Three-client arbiter for a single burst-capable DDR port: fixed priority for
// the display client, round-robin between the others, ownership held until all read beats return.
module ddr_port_arbiter #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 64
) (
    input  logic                      clkddr,
    input  logic                      reset_n,
    input  logic [2:0]                c_acquire,
    input  logic [2:0]                c_read,
    input  logic [2:0]                c_write,
    input  logic [3*ADDR_W-1:0]       c_addr,
    input  logic [23:0]               c_burstcnt,
    input  logic [3*DATA_W-1:0]       c_wdata,
    input  logic [3*(DATA_W/8)-1:0]   c_byteenable,
    output logic [2:0]                c_grant,
    output logic [2:0]                c_busy,
    output logic [2:0]                c_rdata_ready,
    output logic [DATA_W-1:0]         c_rdata,
    output logic                      ddr_acquire,
    output logic                      ddr_read,
    output logic                      ddr_write,
    output logic [ADDR_W-1:0]         ddr_addr,
    output logic [7:0]                ddr_burstcnt,
    output logic [DATA_W-1:0]         ddr_wdata,
    output logic [DATA_W/8-1:0]       ddr_byteenable,
    input  logic                      ddr_busy,
    input  logic                      ddr_rdata_ready,
    input  logic [DATA_W-1:0]         ddr_rdata,
    output logic                      err_underflow
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [1:0]        owner_r, owner_nxt_s;
    logic              rr_ptr_r, rr_ptr_nxt_s;   // 0 selects client 1, 1 selects client 2
    logic [2:0]        grant_r, grant_nxt_s;
    logic [9:0]        cnt_r, cnt_nxt_s;
    logic              err_r, err_nxt_s;

    logic              sel_acq_s, sel_read_s, sel_write_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [7:0]        sel_burst_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [BE_W-1:0]   sel_be_s;
    logic              accept_s;
    logic [10:0]       sum_s, sum_dec_s;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] v;
        v = 3'b000;
        case (idx)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Select the current owner's command fields.
    always_comb begin
        sel_acq_s   = 1'b0;
        sel_read_s  = 1'b0;
        sel_write_s = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_burst_s = 8'd0;
        sel_wdata_s = {DATA_W{1'b0}};
        sel_be_s    = {BE_W{1'b0}};
        case (owner_r)
            2'd0: begin
                sel_acq_s   = c_acquire[0];
                sel_read_s  = c_read[0];
                sel_write_s = c_write[0];
                sel_addr_s  = c_addr[0 +: ADDR_W];
                sel_burst_s = c_burstcnt[7:0];
                sel_wdata_s = c_wdata[0 +: DATA_W];
                sel_be_s    = c_byteenable[0 +: BE_W];
            end
            2'd1: begin
                sel_acq_s   = c_acquire[1];
                sel_read_s  = c_read[1];
                sel_write_s = c_write[1];
                sel_addr_s  = c_addr[ADDR_W +: ADDR_W];
                sel_burst_s = c_burstcnt[15:8];
                sel_wdata_s = c_wdata[DATA_W +: DATA_W];
                sel_be_s    = c_byteenable[BE_W +: BE_W];
            end
            2'd2: begin
                sel_acq_s   = c_acquire[2];
                sel_read_s  = c_read[2];
                sel_write_s = c_write[2];
                sel_addr_s  = c_addr[2*ADDR_W +: ADDR_W];
                sel_burst_s = c_burstcnt[23:16];
                sel_wdata_s = c_wdata[2*DATA_W +: DATA_W];
                sel_be_s    = c_byteenable[2*BE_W +: BE_W];
            end
            default: begin
                sel_acq_s = 1'b0;
            end
        endcase
    end

    // DDR command passthrough; strobes are forced low whenever nobody owns the port.
    always_comb begin
        ddr_read       = 1'b0;
        ddr_write      = 1'b0;
        ddr_acquire    = 1'b0;
        ddr_addr       = {ADDR_W{1'b0}};
        ddr_burstcnt   = 8'd0;
        ddr_wdata      = {DATA_W{1'b0}};
        ddr_byteenable = {BE_W{1'b0}};
        if (state_r == OWNED) begin
            ddr_read       = sel_read_s;
            ddr_write      = sel_write_s;
            ddr_acquire    = sel_acq_s || (cnt_r != 10'd0);
            ddr_addr       = sel_addr_s;
            ddr_burstcnt   = sel_burst_s;
            ddr_wdata      = sel_wdata_s;
            ddr_byteenable = sel_be_s;
        end else begin
            ddr_read = 1'b0;
        end
    end

    assign c_grant       = grant_r;
    assign c_busy        = ~grant_r | (grant_r & {3{ddr_busy}});
    assign c_rdata_ready = grant_r & {3{ddr_rdata_ready}};
    assign c_rdata       = ddr_rdata;
    assign err_underflow = err_r;

    // Outstanding-beat accounting: a beat with nothing outstanding is flagged, never wrapped.
    always_comb begin
        accept_s  = ddr_read && !ddr_busy;
        sum_s     = {1'b0, cnt_r} + (accept_s ? {3'b000, ddr_burstcnt} : 11'd0);
        sum_dec_s = sum_s;
        err_nxt_s = err_r;
        if (ddr_rdata_ready) begin
            if (sum_s == 11'd0) begin
                err_nxt_s = 1'b1;
            end else begin
                sum_dec_s = sum_s - 11'd1;
            end
        end else begin
            sum_dec_s = sum_s;
        end
        if (sum_dec_s > 11'd1023) begin
            cnt_nxt_s = 10'd1023;
        end else begin
            cnt_nxt_s = sum_dec_s[9:0];
        end
    end

    // Arbitration and release.
    always_comb begin
        state_nxt_s  = state_r;
        owner_nxt_s  = owner_r;
        rr_ptr_nxt_s = rr_ptr_r;
        grant_nxt_s  = grant_r;
        case (state_r)
            IDLE: begin
                if (c_acquire != 3'b000) begin
                    state_nxt_s = OWNED;
                    if (c_acquire[0]) begin
                        owner_nxt_s = 2'd0;
                    end else if (c_acquire[1] && c_acquire[2]) begin
                        owner_nxt_s = rr_ptr_r ? 2'd2 : 2'd1;
                    end else if (c_acquire[1]) begin
                        owner_nxt_s = 2'd1;
                    end else begin
                        owner_nxt_s = 2'd2;
                    end
                    if (owner_nxt_s != 2'd0) begin
                        rr_ptr_nxt_s = ~rr_ptr_r;
                    end else begin
                        rr_ptr_nxt_s = rr_ptr_r;
                    end
                    grant_nxt_s = onehot3(owner_nxt_s);
                end else begin
                    grant_nxt_s = 3'b000;
                end
            end
            OWNED: begin
                if (!sel_acq_s && (cnt_nxt_s == 10'd0)) begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = 3'b000;
                end else begin
                    state_nxt_s = OWNED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = 3'b000;
            end
        endcase
    end

    // State, ownership, pointer, counter and sticky error registers.
    always_ff @(posedge clkddr or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            owner_r  <= 2'd0;
            rr_ptr_r <= 1'b0;
            grant_r  <= 3'b000;
            cnt_r    <= 10'd0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            owner_r  <= owner_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            grant_r  <= grant_nxt_s;
            cnt_r    <= cnt_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: directed vector table, corner sequences,
// and randomized traffic against an ownership/beat-count reference model.
module tb_ddr_port_arbiter;

    localparam int AW = 29;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [2:0]      c_acquire, c_read, c_write;
    logic [3*AW-1:0] c_addr;
    logic [23:0]     c_burstcnt;
    logic [3*DW-1:0] c_wdata;
    logic [3*BW-1:0] c_byteenable;
    logic [2:0]      c_grant, c_busy, c_rdata_ready;
    logic [DW-1:0]   c_rdata;
    logic            ddr_acquire, ddr_read, ddr_write;
    logic [AW-1:0]   ddr_addr;
    logic [7:0]      ddr_burstcnt;
    logic [DW-1:0]   ddr_wdata;
    logic [BW-1:0]   ddr_byteenable;
    logic            ddr_busy, ddr_rdata_ready;
    logic [DW-1:0]   ddr_rdata;
    logic            err_underflow;

    ddr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clkddr(clk), .reset_n(reset_n),
        .c_acquire(c_acquire), .c_read(c_read), .c_write(c_write),
        .c_addr(c_addr), .c_burstcnt(c_burstcnt), .c_wdata(c_wdata),
        .c_byteenable(c_byteenable), .c_grant(c_grant), .c_busy(c_busy),
        .c_rdata_ready(c_rdata_ready), .c_rdata(c_rdata),
        .ddr_acquire(ddr_acquire), .ddr_read(ddr_read), .ddr_write(ddr_write),
        .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt), .ddr_wdata(ddr_wdata),
        .ddr_byteenable(ddr_byteenable), .ddr_busy(ddr_busy),
        .ddr_rdata_ready(ddr_rdata_ready), .ddr_rdata(ddr_rdata),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Bench-side stimulus, one entry per client.
    logic [2:0]    acq, rd, wr;
    logic [7:0]    bc [3];
    logic [AW-1:0] ad [3];
    logic [DW-1:0] wd [3];
    logic [BW-1:0] be [3];
    logic          busy, rdy;
    logic [DW-1:0] rdat;

    // Reference model: who owns the port, how many beats are owed, sticky error.
    bit m_owned, n_owned;
    int m_owner, n_owner;
    int m_ptr, n_ptr;
    int m_cnt, n_cnt;
    bit m_err, n_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] acq;
        logic [2:0] rd;
        logic       busy;
        logic       rdy;
        logic [2:0] e_grant;
        logic       e_dacq;
        logic       e_dread;
        logic [2:0] e_cbusy;
        logic [2:0] e_rrdy;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owned = 1'b0; m_owner = 0; m_ptr = 1; m_cnt = 0; m_err = 1'b0;
    endtask

    task automatic clear_inputs();
        acq = 3'b000; rd = 3'b000; wr = 3'b000; busy = 1'b0; rdy = 1'b0; rdat = '0;
        for (int i = 0; i < 3; i++) begin
            bc[i] = 8'd0; ad[i] = '0; wd[i] = '0; be[i] = '0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        m_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drive inputs, let them settle, compare every output with the model, plan next state.
    task automatic step_pre();
        logic [2:0] eg, ecb, err3;
        bit edacq;
        int t;
        c_acquire = acq; c_read = rd; c_write = wr;
        c_addr = {ad[2], ad[1], ad[0]};
        c_burstcnt = {bc[2], bc[1], bc[0]};
        c_wdata = {wd[2], wd[1], wd[0]};
        c_byteenable = {be[2], be[1], be[0]};
        ddr_busy = busy; ddr_rdata_ready = rdy; ddr_rdata = rdat;
        #1;
        eg = m_owned ? (3'b001 << m_owner) : 3'b000;
        ecb = 3'b111;
        if (m_owned) ecb[m_owner] = busy;
        err3 = m_owned ? ({2'b00, rdy} << m_owner) : 3'b000;
        edacq = m_owned && (acq[m_owner] || m_cnt != 0);
        chk("grant", c_grant, eg);
        chk("c_busy", c_busy, ecb);
        chk("c_rdata_ready", c_rdata_ready, err3);
        chk("c_rdata", c_rdata, rdat);
        chk("ddr_acquire", ddr_acquire, edacq);
        chk("ddr_read", ddr_read, m_owned ? rd[m_owner] : 1'b0);
        chk("ddr_write", ddr_write, m_owned ? wr[m_owner] : 1'b0);
        chk("err_underflow", err_underflow, m_err);
        if (m_owned) begin
            chk("ddr_addr", ddr_addr, ad[m_owner]);
            chk("ddr_burstcnt", ddr_burstcnt, bc[m_owner]);
            chk("ddr_wdata", ddr_wdata, wd[m_owner]);
            chk("ddr_byteenable", ddr_byteenable, be[m_owner]);
        end
        t = m_cnt + ((m_owned && rd[m_owner] && !busy) ? int'(bc[m_owner]) : 0);
        n_err = m_err;
        if (rdy) begin
            if (t == 0) n_err = 1'b1;
            else t = t - 1;
        end
        if (t > 1023) t = 1023;
        n_cnt = t; n_owned = m_owned; n_owner = m_owner; n_ptr = m_ptr;
        if (m_owned) begin
            if (!acq[m_owner] && t == 0) n_owned = 1'b0;
        end else if (acq != 3'b000) begin
            n_owned = 1'b1;
            if (acq[0]) n_owner = 0;
            else if (acq[1] && acq[2]) n_owner = m_ptr;
            else n_owner = acq[1] ? 1 : 2;
            if (n_owner != 0) n_ptr = 3 - m_ptr;
        end
    endtask

    task automatic step_post();
        @(posedge clk);
        m_owned = n_owned; m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt; m_err = n_err;
        @(negedge clk);
    endtask

    task automatic step();
        step_pre();
        step_post();
    endtask

    // Return beats until the owed count runs out; ownership must hold until the last one.
    task automatic drain(input int n, input logic [2:0] g);
        rdy = 1'b1;
        for (int i = 1; i < n; i++) begin
            step();
        end
        chk("drain_hold_grant", c_grant, g);
        chk("drain_hold_acquire", ddr_acquire, 1'b1);
        step();
        rdy = 1'b0;
        chk("drain_release_grant", c_grant, 3'b000);
        chk("drain_release_acquire", ddr_acquire, 1'b0);
    endtask

    initial begin
        int exp_seq [4];
        int ow;
        c_acquire = '0; c_read = '0; c_write = '0; c_addr = '0; c_burstcnt = '0;
        c_wdata = '0; c_byteenable = '0; ddr_busy = 1'b0; ddr_rdata_ready = 1'b0; ddr_rdata = '0;
        do_reset();
        #1;
        chk("reset_grant", c_grant, 3'b000);
        chk("reset_busy", c_busy, 3'b111);
        chk("reset_ddr_acquire", ddr_acquire, 1'b0);
        chk("reset_err", err_underflow, 1'b0);
        @(negedge clk);

        // Directed table: 0 and 2 contend, 2 tries to read while 0 owns, then 2 gets the port.
        tbl[0] = '{3'b101, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000};
        tbl[1] = '{3'b101, 3'b101, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 3'b110, 3'b000};
        tbl[2] = '{3'b100, 3'b100, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'b110, 3'b001};
        tbl[3] = '{3'b100, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'b110, 3'b001};
        tbl[4] = '{3'b100, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'b110, 3'b001};
        tbl[5] = '{3'b100, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'b110, 3'b001};
        tbl[6] = '{3'b100, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000};
        tbl[7] = '{3'b100, 3'b100, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 3'b111, 3'b000};
        tbl[8] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 3'b011, 3'b000};
        tbl[9] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000};
        for (int i = 0; i < 3; i++) begin
            bc[i] = 8'd4; ad[i] = AW'(32'h100 * (i + 1)); wd[i] = DW'(64'h1111 * (i + 1)); be[i] = BW'(i + 1);
        end
        for (int v = 0; v < 10; v++) begin
            acq = tbl[v].acq; rd = tbl[v].rd; busy = tbl[v].busy; rdy = tbl[v].rdy;
            step_pre();
            chk("tbl_grant", c_grant, tbl[v].e_grant);
            chk("tbl_ddr_acquire", ddr_acquire, tbl[v].e_dacq);
            chk("tbl_ddr_read", ddr_read, tbl[v].e_dread);
            chk("tbl_c_busy", c_busy, tbl[v].e_cbusy);
            chk("tbl_rdata_ready", c_rdata_ready, tbl[v].e_rrdy);
            step_post();
        end

        // Round robin between clients 1 and 2, each releasing after a 4-beat read.
        do_reset();
        exp_seq = '{1, 2, 1, 2};
        acq = 3'b110;
        step();
        for (int k = 0; k < 4; k++) begin
            ow = exp_seq[k];
            chk("rr_grant", c_grant, 3'b001 << ow);
            rd[ow] = 1'b1; bc[ow] = 8'd4;
            step();
            rd[ow] = 1'b0; rdy = 1'b1;
            step(); step(); step();
            acq[ow] = 1'b0;
            step();
            rdy = 1'b0; acq[ow] = 1'b1;
            chk("rr_gap_idle", c_grant, 3'b000);
            step();
        end

        // Long burst outlives the acquire request.
        do_reset();
        acq = 3'b001;
        step();
        rd[0] = 1'b1; bc[0] = 8'd50;
        step();
        rd[0] = 1'b0; acq = 3'b000;
        drain(50, 3'b001);

        // New burst accepted while a beat returns: 3 + 8 - 1 beats still owed.
        do_reset();
        acq = 3'b001;
        step();
        rd[0] = 1'b1; bc[0] = 8'd3;
        step();
        bc[0] = 8'd8; rdy = 1'b1;
        step();
        rd[0] = 1'b0; acq = 3'b000;
        drain(10, 3'b001);

        // Counter saturates at 1023.
        do_reset();
        acq = 3'b010;
        step();
        rd[1] = 1'b1; bc[1] = 8'd255;
        repeat (5) step();
        rd[1] = 1'b0; acq = 3'b000;
        drain(1023, 3'b010);

        // Asynchronous reset in the middle of a 20-beat burst.
        do_reset();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("err_stray_pre", err_underflow, 1'b1);
        acq = 3'b001;
        step();
        rd[0] = 1'b1; bc[0] = 8'd20;
        step();
        rd[0] = 1'b0; rdy = 1'b1;
        repeat (3) step();
        rd[0] = 1'b1; rdy = 1'b0;
        step_pre();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_grant", c_grant, 3'b000);
        chk("rst_mid_read", ddr_read, 1'b0);
        chk("rst_mid_write", ddr_write, 1'b0);
        chk("rst_mid_acquire", ddr_acquire, 1'b0);
        chk("rst_mid_err", err_underflow, 1'b0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        acq = 3'b000; rd = 3'b000; rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("err_stray_post", err_underflow, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(3, 0) == 0) acq[i] = ~acq[i];
                rd[i] = ($urandom_range(3, 0) == 0);
                wr[i] = ($urandom_range(3, 0) == 0);
                bc[i] = 8'($urandom_range(6, 0));
                ad[i] = AW'($urandom);
                wd[i] = {$urandom, $urandom};
                be[i] = 8'($urandom);
            end
            busy = ($urandom_range(2, 0) == 0);
            rdy = ($urandom_range(1, 0) == 0);
            rdat = {$urandom, $urandom};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
